armstrong_scan_ctrl: RTL and testbench
======================================

Name: armstrong_scan_ctrl

Overview:
Sequential controller that scans a programmed range [lo, hi] of 9-bit numbers and reports every Armstrong number it finds.
- Armstrong rule: sum of the cubes of the decimal digits equals the number.
- Each candidate is checked with a shared multi-cycle digit/cube accumulator, one digit per cycle.
- Results leave on a valid/ready stream.
- Sits between a host register interface (start/range) and a downstream result consumer.

Parameters:
NUM_W, 9, candidate width (range 0..2^NUM_W-1)
ACC_W, 12, cube-sum accumulator width (3*9^3 = 2187 fits; no truncation permitted)
MAX_DIGITS, 3, decimal digits processed per candidate

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a scan; ignored while busy=1
lo  in  NUM_W  range low bound, sampled when start is accepted
hi  in  NUM_W  range high bound, sampled when start is accepted
busy  out  1  high from the cycle after start is accepted until done
found_valid  out  1  result available
found_num  out  NUM_W  Armstrong number found; stable while found_valid=1
found_ready  in  1  consumer accepts when found_valid=1 and found_ready=1
done  out  1  one-cycle pulse when the scan completes
hit_count  out  4  number of results emitted in the current or last scan (see Optional Feature)

Behaviour:
- Reset (async, active-high): state=IDLE. busy, found_valid, done, found_num and hit_count are all 0. Reset mid-scan aborts immediately; no done pulse is generated.
- Candidate register is NUM_W+1 bits, so hi = 2^NUM_W-1 terminates without wrap-around.
- FSM states: IDLE, LOAD, DIG, CMP, EMIT, NEXT, FIN.
  - IDLE: on start, latch lo/hi, set cand=lo, go to LOAD.
  - LOAD: if cand > hi, go to FIN (covers lo > hi, which produces no results). Otherwise set t=cand, acc=0, dcnt=0, go to DIG.
  - DIG: acc += (t%10)^3; t = t/10; dcnt++. Always exactly MAX_DIGITS cycles; leading zeros contribute 0. After the last digit, go to CMP.
  - CMP: if acc == cand (zero-extended to ACC_W), load found_num=cand, assert found_valid, go to EMIT. Otherwise go to NEXT.
  - EMIT: hold found_valid and found_num until found_ready=1. In the accept cycle, deassert found_valid, increment hit_count (saturate at 15), go to NEXT. The scan stalls while waiting.
  - NEXT: cand++, go to LOAD.
  - FIN: pulse done for 1 cycle, go to IDLE.
- Fixed latency per non-hit candidate: LOAD + 3 DIG + CMP + NEXT = 6 cycles.
- A hit adds 1 or more EMIT cycles.
- start asserted in the same cycle as FIN is ignored; it is accepted in IDLE only.
- found_ready is ignored when found_valid=0.
- Expected hits over 0..511: 0, 1, 153, 370, 371, 407.

Optional Feature:
Macro ARMSTRONG_SCAN_COUNT_EN.
- Defined: hit_count register present; cleared when start is accepted, incremented per accepted result, saturating at 15.
- Undefined: the register is not built and hit_count is tied to 0.

Decomposition:
Shared package armstrong_pkg holds:
- NUM_W, ACC_W, MAX_DIGITS constants
- FSM state typedef/encoding (IDLE..FIN)
- the constant 10 used as the digit radix

One sub-module is natural: armstrong_digit_acc.
- Inputs: load, step, value.
- Outputs: acc, t.
- Performs one divide-by-10/cube/add per step.
- The FSM sequences it and owns the comparison and handshake.

Test Plan:
1. lo=0, hi=511, found_ready=1 constantly -> found_num sequence 0, 1, 153, 370, 371, 407; done pulses once; hit_count=6; busy low after done.
2. lo=150, hi=160 -> single result 153; hit_count=1; done 6*11+1 EMIT cycle (+FIN) after LOAD start, ±0 cycles from the model.
3. Backpressure: lo=369, hi=372, found_ready low for 10 cycles on each result -> 370 held stable for 10 cycles, then 371; no result dropped or duplicated.
4. lo=200, hi=100 -> no found_valid; done pulses 2 cycles after start (LOAD, FIN); hit_count=0.
5. lo=510, hi=511 -> no hits; scan terminates with done (no wrap back to 0).
6. Reset asserted while in EMIT for 407 -> found_valid, busy and hit_count go to 0 asynchronously. A new start with lo=0, hi=1 then yields 0, 1.

Source files
------------

// File: rtl/armstrong_pkg.sv
// Shared constants, FSM encoding and cube helper for the Armstrong range scanner.
package armstrong_pkg;

  localparam int unsigned NUM_W      = 9;
  localparam int unsigned ACC_W      = 12;
  localparam int unsigned MAX_DIGITS = 3;
  localparam int unsigned RADIX      = 10;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned DCNT_W     = $clog2(MAX_DIGITS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIG  = 3'd2,
    CMP  = 3'd3,
    EMIT = 3'd4,
    NEXT = 3'd5,
    FIN  = 3'd6
  } state_e;

  // Cube of one decimal digit, widened so 3*9^3 never truncates.
  function automatic logic [ACC_W-1:0] cube(input logic [3:0] d);
    logic [ACC_W-1:0] x;
    x = ACC_W'(d);
    return x * x * x;
  endfunction

endpackage

// File: rtl/armstrong_scan_ctrl_if.sv
// Host control plus result stream bundle for armstrong_scan_ctrl.
interface armstrong_scan_ctrl_if;
  import armstrong_pkg::*;

  logic             start;
  logic [NUM_W-1:0] lo;
  logic [NUM_W-1:0] hi;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hit_count;
  logic             found_valid;
  logic [NUM_W-1:0] found_num;
  logic             found_ready;

  modport master (
    input  start, lo, hi, found_ready,
    output busy, done, hit_count, found_valid, found_num
  );

  modport slave (
    output start, lo, hi, found_ready,
    input  busy, done, hit_count, found_valid, found_num
  );

endinterface

// File: rtl/armstrong_digit_acc.sv
// Digit peeler: each step adds (t%10)^3 to acc and divides t by 10.
module armstrong_digit_acc
  import armstrong_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [NUM_W-1:0] value,
  output logic [ACC_W-1:0] acc,
  output logic [NUM_W-1:0] t
);

  logic [NUM_W-1:0] t_q, t_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       digit;

  // Next value of the remaining quotient and running cube sum.
  always_comb begin
    t_d   = t_q;
    acc_d = acc_q;
    digit = 4'(t_q % NUM_W'(RADIX));
    if (load) begin
      t_d   = value;
      acc_d = '0;
    end else if (step) begin
      acc_d = acc_q + cube(digit);
      t_d   = t_q / NUM_W'(RADIX);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_q   <= '0;
      acc_q <= '0;
    end else begin
      t_q   <= t_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;
  assign t   = t_q;

endmodule

// File: rtl/armstrong_scan_ctrl.sv
// Scans [lo, hi] and streams out every Armstrong number found.
// Optional hit counter enabled by defining ARMSTRONG_SCAN_COUNT_EN.
module armstrong_scan_ctrl
  import armstrong_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  armstrong_scan_ctrl_if.master io
);

  state_e            state_q, state_d;
  logic [NUM_W:0]    cand_q, cand_d;
  logic [NUM_W-1:0]  hi_q, hi_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              found_valid_q, found_valid_d;
  logic [NUM_W-1:0]  found_num_q, found_num_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              acc_load, acc_step;
  logic [ACC_W-1:0]  dig_acc;
  logic [NUM_W-1:0]  dig_t;
`ifdef ARMSTRONG_SCAN_COUNT_EN
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
`endif

  armstrong_digit_acc u_digit_acc (
    .clk   (clk),
    .rst   (rst),
    .load  (acc_load),
    .step  (acc_step),
    .value (cand_q[NUM_W-1:0]),
    .acc   (dig_acc),
    .t     (dig_t)
  );

  // Next-state, datapath control and registered-output next values.
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    hi_d          = hi_q;
    dcnt_d        = dcnt_q;
    found_valid_d = found_valid_q;
    found_num_d   = found_num_q;
    acc_load      = 1'b0;
    acc_step      = 1'b0;
`ifdef ARMSTRONG_SCAN_COUNT_EN
    hit_cnt_d     = hit_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (io.start) begin
          hi_d    = io.hi;
          cand_d  = {1'b0, io.lo};
`ifdef ARMSTRONG_SCAN_COUNT_EN
          hit_cnt_d = '0;
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (cand_q > {1'b0, hi_q}) begin
          state_d = FIN;
        end else begin
          acc_load = 1'b1;
          dcnt_d   = '0;
          state_d  = DIG;
        end
      end
      DIG: begin
        acc_step = 1'b1;
        dcnt_d   = dcnt_q + 1'b1;
        if (dcnt_q == DCNT_W'(MAX_DIGITS - 1)) state_d = CMP;
      end
      CMP: begin
        if (dig_acc == ACC_W'(cand_q)) begin
          found_num_d   = cand_q[NUM_W-1:0];
          found_valid_d = 1'b1;
          state_d       = EMIT;
        end else begin
          state_d = NEXT;
        end
      end
      EMIT: begin
        if (io.found_ready) begin
          found_valid_d = 1'b0;
`ifdef ARMSTRONG_SCAN_COUNT_EN
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
`endif
          state_d = NEXT;
        end
      end
      NEXT: begin
        cand_d  = cand_q + 1'b1;
        state_d = LOAD;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // State and control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cand_q        <= '0;
      hi_q          <= '0;
      dcnt_q        <= '0;
      found_valid_q <= 1'b0;
      found_num_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      hi_q          <= hi_d;
      dcnt_q        <= dcnt_d;
      found_valid_q <= found_valid_d;
      found_num_q   <= found_num_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

`ifdef ARMSTRONG_SCAN_COUNT_EN
  // Per-scan saturating count of accepted results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_cnt_q <= '0;
    else     hit_cnt_q <= hit_cnt_d;
  end
  assign io.hit_count = hit_cnt_q;
`else
  assign io.hit_count = '0;
`endif

  assign io.busy        = busy_q;
  assign io.done        = done_q;
  assign io.found_valid = found_valid_q;
  assign io.found_num   = found_num_q;

  // Every digit must have been consumed by the time the sum is compared.
  a_digits_consumed: assert property (@(posedge clk) disable iff (rst)
    (state_q == CMP) |-> (dig_t == '0));

endmodule

// File: tb/tb_armstrong_scan_ctrl.sv
// Randomized self-checking bench for armstrong_scan_ctrl against a digit-sum model.
module tb_armstrong_scan_ctrl;
  import armstrong_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  armstrong_scan_ctrl_if bus ();

  armstrong_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference rule: sum of cubes of decimal digits equals the number.
  function automatic bit is_arm(input int n);
    int s = 0;
    int m = n;
    for (int i = 0; i < 3; i++) begin
      s += (m % 10) * (m % 10) * (m % 10);
      m = m / 10;
    end
    return s == n;
  endfunction

  function automatic int hc_exp(input int n);
`ifdef ARMSTRONG_SCAN_COUNT_EN
    return (n > 15) ? 15 : n;
`else
    return 0 * n;
`endif
  endfunction

  // One complete scan; each result is stalled a random count in [smin, smax].
  task automatic run_scan(input int lo, input int hi, input int smin, input int smax);
    int  exp_q[$];
    int  n_cand, emit_exp, e, idx, stall_left, held, k;
    bit  in_res, seen_done;
    exp_q.delete();
    n_cand = (hi >= lo) ? hi - lo + 1 : 0;
    for (int n = lo; n <= hi; n++) if (is_arm(n)) exp_q.push_back(n);
    emit_exp = 0; idx = 0; in_res = 0; seen_done = 0; stall_left = 0; held = 0; e = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.lo    = NUM_W'(lo);
    bus.hi    = NUM_W'(hi);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    while (!seen_done && e < 4000) begin
      bus.start = (e == 2 && n_cand > 0);
      if (bus.start) begin
        bus.lo = NUM_W'($urandom_range(0, 511));
        bus.hi = NUM_W'($urandom_range(0, 511));
      end
      if (bus.found_valid) begin
        if (!in_res) begin
          in_res     = 1;
          k          = $urandom_range(smin, smax);
          stall_left = k;
          held       = int'(bus.found_num);
          emit_exp  += k + 1;
        end
        if (stall_left > 0) begin
          bus.found_ready = 1'b0;
          stall_left--;
        end else begin
          bus.found_ready = 1'b1;
          check("found_stable", int'(bus.found_num), held);
          check("found_num", int'(bus.found_num), (idx < exp_q.size()) ? exp_q[idx] : -1);
          idx++;
          in_res = 0;
        end
      end else begin
        bus.found_ready = 1'($urandom_range(0, 1));
      end
      if (bus.done) begin
        seen_done = 1;
        check("done_cycle", e, 6 * n_cand + emit_exp + 1);
        check("busy_at_done", int'(bus.busy), 1);
        check("hit_count", int'(bus.hit_count), hc_exp(exp_q.size()));
      end else begin
        @(negedge clk);
        e++;
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("result_count", idx, exp_q.size());
    // A start presented during the done cycle must be dropped.
    bus.start = 1'b1;
    bus.lo    = '0;
    bus.hi    = '0;
    @(negedge clk);
    bus.start = 1'b0;
    check("idle_after_fin", int'(bus.busy), 0);
    check("done_single", int'(bus.done), 0);
    check("valid_after_fin", int'(bus.found_valid), 0);
    @(negedge clk);
    check("start_in_fin_ignored", int'(bus.busy), 0);
  endtask

  // Reset while 407 is being held, after 370 and 371 were accepted.
  task automatic reset_in_emit();
    int acc = 0;
    int e = 0;
    bit hold = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.lo    = NUM_W'(370);
    bus.hi    = NUM_W'(511);
    bus.found_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (!hold && e < 2000) begin
      @(negedge clk);
      e++;
      if (bus.found_valid) begin
        if (acc < 2) begin
          bus.found_ready = 1'b1;
          acc++;
        end else begin
          bus.found_ready = 1'b0;
          hold = 1;
        end
      end else begin
        bus.found_ready = 1'b0;
      end
    end
    check("hold_reached", int'(hold), 1);
    check("hold_num", int'(bus.found_num), 407);
    repeat (2) @(negedge clk);
    check("hold_valid", int'(bus.found_valid), 1);
    check("hold_hit_count", int'(bus.hit_count), hc_exp(2));
    #2 rst = 1'b1;
    #1;
    check("arst_valid", int'(bus.found_valid), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_hit_count", int'(bus.hit_count), 0);
    check("arst_found_num", int'(bus.found_num), 0);
    @(negedge clk);
    check("arst_no_done", int'(bus.done), 0);
    rst = 1'b0;
    run_scan(0, 1, 0, 2);
  endtask

  initial begin
    int lo, hi;
    bus.start       = 1'b0;
    bus.lo          = '0;
    bus.hi          = '0;
    bus.found_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.found_valid), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_found_num", int'(bus.found_num), 0);
    check("rst_hit_count", int'(bus.hit_count), 0);
    rst = 1'b0;

    run_scan(0, 511, 0, 0);
    run_scan(150, 160, 0, 0);
    run_scan(369, 372, 10, 10);
    run_scan(200, 100, 0, 0);
    run_scan(510, 511, 0, 0);
    reset_in_emit();

    for (int i = 0; i < 6; i++) begin
      lo = $urandom_range(0, 511);
      hi = (i == 5) ? lo - 1 - int'($urandom_range(0, 3))
                    : $urandom_range(lo, (lo + 80 > 511) ? 511 : lo + 80);
      if (hi < 0) hi = 0;
      run_scan(lo, hi, 0, 3);
    end
    run_scan(360, 420, 0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
